// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller and the datapath muxes it drives.
// The extender mux imports the IMM_* codes from here so both sides agree.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ECALL, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational opcode decoder: instruction class plus the datapath selects
// that the FSM latches in ID. Don't-care fields decode to 0.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t instr_class,
  output logic [2:0]   imm_sel,
  output logic         alu_src_b,
  output logic [1:0]   wb_sel,
  output logic         is_ecall,
  output logic         illegal
);

  logic unused_fields;
  assign unused_fields = ^{instr[31:15], instr[11:7]};

  always_comb begin
    instr_class = CLS_ILLEGAL;
    imm_sel     = IMM_I;
    alu_src_b   = 1'b0;
    wb_sel      = WB_ALU;
    case (instr[6:0])
      OPC_OP:     instr_class = CLS_OP;
      OPC_OP_IMM: begin instr_class = CLS_OP_IMM; alu_src_b = 1'b1; end
      OPC_LOAD:   begin instr_class = CLS_LOAD; alu_src_b = 1'b1; wb_sel = WB_LOAD; end
      OPC_STORE:  begin instr_class = CLS_STORE; imm_sel = IMM_S; alu_src_b = 1'b1; end
      OPC_BRANCH: begin instr_class = CLS_BRANCH; imm_sel = IMM_B; end
      OPC_LUI:    begin instr_class = CLS_LUI; imm_sel = IMM_U; alu_src_b = 1'b1; end
      OPC_AUIPC:  begin instr_class = CLS_AUIPC; imm_sel = IMM_U; alu_src_b = 1'b1; end
      OPC_JAL:    begin instr_class = CLS_JAL; imm_sel = IMM_J; wb_sel = WB_PC4; end
      OPC_JALR:   begin instr_class = CLS_JALR; alu_src_b = 1'b1; wb_sel = WB_PC4; end
      // Only funct3=0 SYSTEM is treated as ECALL; CSR forms fall through as NOPs.
      OPC_SYSTEM: if (instr[14:12] == 3'b000) instr_class = CLS_ECALL;
      default:    instr_class = CLS_ILLEGAL;
    endcase
  end

  assign is_ecall = (instr_class == CLS_ECALL);
  assign illegal  = (instr_class == CLS_ILLEGAL);

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over a shared datapath.
// Decoded selects are latched in ID and held until the instruction retires.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_src_b,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [2:0]  state
);

  state_t       state_q;
  instr_class_t cls_q;

  instr_class_t dec_class;
  logic [2:0]   dec_imm_sel;
  logic         dec_alu_src_b;
  logic [1:0]   dec_wb_sel;
  logic         dec_is_ecall;
  logic         dec_illegal;

  riscv_ctrl_decode u_decode (
    .instr       (instr),
    .instr_class (dec_class),
    .imm_sel     (dec_imm_sel),
    .alu_src_b   (dec_alu_src_b),
    .wb_sel      (dec_wb_sel),
    .is_ecall    (dec_is_ecall),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IF;
      cls_q     <= CLS_ILLEGAL;
      imm_sel   <= IMM_I;
      alu_src_b <= 1'b0;
      wb_sel    <= WB_ALU;
      halted    <= 1'b0;
    end else begin
      case (state_q)
        ST_IF:  if (imem_ready) state_q <= ST_ID;
        ST_ID: begin
          cls_q     <= dec_illegal ? CLS_ILLEGAL : dec_class;
          imm_sel   <= dec_imm_sel;
          alu_src_b <= dec_alu_src_b;
          wb_sel    <= dec_wb_sel;
          if (dec_is_ecall) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end else begin
            state_q <= ST_EX;
          end
        end
        ST_EX: begin
          if (cls_q == CLS_BRANCH)
            state_q <= ST_IF;
          else if (cls_q == CLS_LOAD || cls_q == CLS_STORE)
            state_q <= ST_MEM;
          else
            state_q <= ST_WB;
        end
        ST_MEM: if (dmem_ready) state_q <= (cls_q == CLS_LOAD) ? ST_WB : ST_IF;
        ST_WB:   state_q <= ST_IF;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IF;
      endcase
    end
  end

  // Moore enables from the current state; only ir_we and the store pc_we
  // look at ready, and both are suppressed while rst is asserted.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req = 1'b1;
        ir_we    = imem_ready & ~rst;
      end
      ST_EX: begin
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_re = (cls_q == CLS_LOAD);
        dmem_we = (cls_q == CLS_STORE);
        pc_we   = (cls_q == CLS_STORE) & dmem_ready & ~rst;
      end
      ST_WB: begin
        reg_we = (cls_q != CLS_ILLEGAL);
        pc_we  = 1'b1;
        pc_sel = (cls_q == CLS_JAL)  ? PC_BRANCH :
                 (cls_q == CLS_JALR) ? PC_JALR   : PC_PLUS4;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed table, trace-model random stream,
// and hand sequences for ECALL halt and reset during a memory wait.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, imem_ready, dmem_ready, branch_taken;
  logic [31:0] instr;
  logic        imem_req, ir_we, pc_we, dmem_re, dmem_we, reg_we, halted, alu_src_b;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  imm_sel, state;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken), .imem_req(imem_req),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_sel(imm_sel),
    .alu_src_b(alu_src_b), .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: expected per-cycle trace ----------------
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4,
                 K_JALR = 5, K_ILL = 6, K_ECALL = 7;

  typedef struct {
    logic       imem_ready, dmem_ready, branch_taken;
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic       dmem_re, dmem_we, reg_we, halted;
    logic       chk_dec;
    logic [2:0] imm;
    logic       alub;
    logic [1:0] wb;
  } cyc_t;

  cyc_t q[$];

  function automatic int spec_kind(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return K_ALU;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b1110011: return (ins[14:12] == 3'b000) ? K_ECALL : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [5:0] spec_fields(input logic [31:0] ins);
    case (ins[6:0])  // {imm_sel, alu_src_b, wb_sel}
      7'b0010011: return {3'd0, 1'b1, 2'd0};
      7'b0000011: return {3'd0, 1'b1, 2'd1};
      7'b0100011: return {3'd1, 1'b1, 2'd0};
      7'b1100011: return {3'd2, 1'b0, 2'd0};
      7'b0110111, 7'b0010111: return {3'd3, 1'b1, 2'd0};
      7'b1101111: return {3'd4, 1'b0, 2'd2};
      7'b1100111: return {3'd0, 1'b1, 2'd2};
      default:    return 6'd0;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st, input logic [5:0] f, input logic dec);
    cyc_t c;
    c.imem_ready = 1'($urandom_range(0, 1));
    c.dmem_ready = 1'($urandom_range(0, 1));
    c.branch_taken = 1'($urandom_range(0, 1));
    c.st = st; c.imem_req = 0; c.ir_we = 0; c.pc_we = 0; c.pc_sel = 0;
    c.dmem_re = 0; c.dmem_we = 0; c.reg_we = 0; c.halted = 0;
    c.chk_dec = dec; c.imm = f[5:3]; c.alub = f[2]; c.wb = f[1:0];
    return c;
  endfunction

  task automatic build(input logic [31:0] ins, input int wi, input int wd, input logic bt);
    int k = spec_kind(ins);
    logic [5:0] f = spec_fields(ins);
    cyc_t c;
    for (int i = 0; i <= wi; i++) begin
      c = blank(3'd0, f, 1'b0);
      c.imem_ready = (i == wi); c.imem_req = 1; c.ir_we = (i == wi);
      q.push_back(c);
    end
    q.push_back(blank(3'd1, f, 1'b0));
    if (k == K_ECALL) return;
    c = blank(3'd2, f, 1'b1);
    if (k == K_BR) begin
      c.branch_taken = bt; c.pc_we = 1; c.pc_sel = {1'b0, bt};
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i <= wd; i++) begin
        c = blank(3'd3, f, 1'b1);
        c.dmem_ready = (i == wd);
        c.dmem_re = (k == K_LOAD); c.dmem_we = (k == K_STORE);
        c.pc_we = (k == K_STORE) && (i == wd);
        q.push_back(c);
      end
      if (k == K_STORE) return;
    end
    c = blank(3'd4, f, 1'b1);
    c.reg_we = (k != K_ILL); c.pc_we = 1;
    c.pc_sel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    q.push_back(c);
  endtask

  // Entered and left at posedge+1.
  task automatic apply(input cyc_t c);
    imem_ready = c.imem_ready; dmem_ready = c.dmem_ready; branch_taken = c.branch_taken;
    @(negedge clk);
    chk("trace_ctl",
        {state, imem_req, ir_we, pc_we, (pc_we ? pc_sel : 2'd0), dmem_re, dmem_we, reg_we, halted},
        {c.st, c.imem_req, c.ir_we, c.pc_we, (c.pc_we ? c.pc_sel : 2'd0),
         c.dmem_re, c.dmem_we, c.reg_we, c.halted});
    if (c.chk_dec) chk("trace_dec", {imm_sel, alu_src_b, wb_sel}, {c.imm, c.alub, c.wb});
    @(posedge clk); #1;
  endtask

  task automatic run_trace(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) apply(q.pop_front());
    q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [31:0] ins;
    int          wi, wd;
    logic        bt;
    int          cycles, ireq, dmem, regs;
    logic [1:0]  psel;
    logic [2:0]  imm;
    logic        alub;
    logic [1:0]  wb;
  } vec_t;

  vec_t vt[9];

  task automatic measure(input vec_t v);
    int cyc = 0, ni = 0, nd = 0, nr = 0, np = 0, iw = 0, dw = 0;
    logic [1:0] ps = 0;
    logic done = 0;
    instr = v.ins; branch_taken = v.bt;
    while (!done && cyc < 50) begin
      imem_ready = (state == 3'd0) && (iw == v.wi);
      dmem_ready = (state == 3'd3) && (dw == v.wd);
      @(negedge clk);
      cyc++;
      if (imem_req) ni++;
      if (dmem_re || dmem_we) nd++;
      if (reg_we) nr++;
      if (pc_we) begin np++; ps = pc_sel; done = 1; end
      if (state == 3'd0) iw++;
      if (state == 3'd3) dw++;
      if (done) begin
        chk({v.name, "_imm"}, imm_sel, v.imm);
        chk({v.name, "_alub"}, alu_src_b, v.alub);
        chk({v.name, "_wb"}, wb_sel, v.wb);
      end
      @(posedge clk); #1;
    end
    if (!done) $display("FAIL %s_timeout: no pc_we after %0d cycles", v.name, cyc);
    chk({v.name, "_cycles"}, cyc, v.cycles);
    chk({v.name, "_imem_req_cycles"}, ni, v.ireq);
    chk({v.name, "_dmem_cycles"}, nd, v.dmem);
    chk({v.name, "_reg_we_pulses"}, nr, v.regs);
    chk({v.name, "_pc_we_pulses"}, np, 1);
    chk({v.name, "_pc_sel"}, ps, v.psel);
  endtask

  task automatic check_reset(input string name);
    @(negedge clk);
    chk(name, {state, imm_sel, alu_src_b, wb_sel, halted, ir_we, pc_we, reg_we, dmem_re, dmem_we},
        {3'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
  endtask

  logic [6:0]  ops[11];
  logic [31:0] r;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1111111, 7'b0001111};
    vt[0] = '{"addi", 32'hFFF00093, 0, 0, 1'b0, 4, 1, 0, 1, 2'd0, 3'd0, 1'b1, 2'd0};
    vt[1] = '{"lw",   32'h0000A103, 2, 3, 1'b0, 10, 3, 4, 1, 2'd0, 3'd0, 1'b1, 2'd1};
    vt[2] = '{"beq_t", 32'h00208463, 0, 0, 1'b1, 3, 1, 0, 0, 2'd1, 3'd2, 1'b0, 2'd0};
    vt[3] = '{"beq_nt", 32'h00208463, 0, 0, 1'b0, 3, 1, 0, 0, 2'd0, 3'd2, 1'b0, 2'd0};
    vt[4] = '{"jalr", 32'h000080E7, 0, 0, 1'b0, 4, 1, 0, 1, 2'd2, 3'd0, 1'b1, 2'd2};
    vt[5] = '{"sw",   32'h0020A023, 0, 2, 1'b0, 6, 1, 3, 0, 2'd0, 3'd1, 1'b1, 2'd0};
    vt[6] = '{"jal",  32'h008000EF, 1, 0, 1'b0, 5, 2, 0, 1, 2'd1, 3'd4, 1'b0, 2'd2};
    vt[7] = '{"illegal", 32'h0000007F, 0, 0, 1'b0, 4, 1, 0, 0, 2'd0, 3'd0, 1'b0, 2'd0};
    vt[8] = '{"lui",  32'h000010B7, 0, 0, 1'b0, 4, 1, 0, 1, 2'd0, 3'd3, 1'b1, 2'd0};

    rst = 1; imem_ready = 0; dmem_ready = 0; branch_taken = 0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1 imem_ready = 1;
    check_reset("reset_state");
    rst = 0;

    for (int i = 0; i < 9; i++) measure(vt[i]);

    // Random instruction stream against the trace model.
    for (int n = 0; n < 200; n++) begin
      r = $urandom();
      instr = {r[31:7], ops[$urandom_range(0, 10)]};
      build(instr, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      run_trace(1000);
    end

    // Reset while a load waits on dmem.
    instr = 32'h0000A103;
    build(instr, 0, 6, 1'b0);
    run_trace(5);
    rst = 1; dmem_ready = 1;
    @(negedge clk);
    chk("rst_in_load_wait_we", {reg_we, pc_we}, 2'b00);
    @(posedge clk); #1;
    rst = 0; dmem_ready = 0; imem_ready = 0;
    @(negedge clk);
    chk("after_rst_load", {state, dmem_re, dmem_we, reg_we, pc_we}, {3'd0, 4'b0000});
    @(posedge clk); #1;
    instr = 32'hFFF00093;
    build(instr, 0, 0, 1'b0);
    run_trace(1000);

    // Reset beats dmem_ready on a store.
    instr = 32'h0020A023;
    build(instr, 0, 3, 1'b0);
    run_trace(4);
    rst = 1; dmem_ready = 1;
    @(negedge clk);
    chk("rst_priority_store_pc_we", pc_we, 1'b0);
    @(posedge clk); #1;
    rst = 0; dmem_ready = 0; imem_ready = 0;
    @(negedge clk);
    chk("after_rst_store", {state, dmem_we, pc_we}, {3'd0, 2'b00});
    @(posedge clk); #1;

    // SW then ECALL, which must park in HALT.
    instr = 32'h0020A023;
    build(instr, 1, 2, 1'b0);
    run_trace(1000);
    instr = 32'h00000073;
    build(instr, 1, 0, 1'b0);
    run_trace(1000);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_hold",
          {state, halted, imem_req, ir_we, pc_we, dmem_re, dmem_we, reg_we},
          {3'd5, 1'b1, 6'b000000});
      @(posedge clk); #1;
    end
    rst = 1; imem_ready = 1;
    @(posedge clk); #1;
    check_reset("reset_from_halt");
    rst = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
